// File: rtl/lsu_mmio_unit_pkg.sv
// lsu_mmio_unit_pkg: funct3 encodings, store lane-mask and load-extend helpers
package lsu_mmio_unit_pkg;
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } f3_e;
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    return f3 == F3_B ? 4'b0001 << a : f3 == F3_H ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
    logic [7:0] b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    return f3 == F3_B ? {{24{b[7]}}, b} : f3 == F3_BU ? {24'h0, b} :
           f3 == F3_H ? {{16{h[15]}}, h} : f3 == F3_HU ? {16'h0, h} : d;
  endfunction
endpackage

// File: rtl/lsu_mmio_unit_if.sv
// lsu_mmio_unit_if: core request/load return, data-memory and UART TX signals; master=core side, slave=lsu
interface lsu_mmio_unit_if #(parameter int ADDR_W = 32, parameter int CNT_W = 4);
  logic              req_valid, req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_stall, req_err, ld_valid;
  logic [31:0]       ld_data;
  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_mask;
  logic [7:0]        uart_data;
  logic              uart_valid, uart_ready;
  logic [CNT_W-1:0]  fifo_count;
  modport master(
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, uart_ready,
    input  req_stall, req_err, ld_valid, ld_data, mem_cs, mem_we, mem_addr, mem_wdata, mem_mask,
           uart_data, uart_valid, fifo_count
  );
  modport slave(
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, uart_ready,
    output req_stall, req_err, ld_valid, ld_data, mem_cs, mem_we, mem_addr, mem_wdata, mem_mask,
           uart_data, uart_valid, fifo_count
  );
endinterface

// File: rtl/lsu_mmio_unit_tx_byte_fifo.sv
// tx_byte_fifo: registered-storage FIFO (clk, rst_n sync low; push/din in, pop in, dout/full/empty/count out)
module tx_byte_fifo #(parameter int DEPTH = 8, parameter int WIDTH = 8) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    do_push = push & ~full;
    do_pop = pop & ~empty;
    dout = mem[rd];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr] <= din;
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/lsu_mmio_unit.sv
// lsu_mmio_unit: load/store unit (clk, rst_n sync low, bus=slave: core req/ld, data memory, UART TX byte FIFO)
module lsu_mmio_unit
  import lsu_mmio_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MMIO_BIT = 31,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  lsu_mmio_unit_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  logic [2:0] f3, ld_f3_q;
  logic [1:0] a, ld_a_q;
  logic mmio, bad, stall, accept, cs, we, push, full, empty, ld_valid_q, ld_mmio_q;
  logic [7:0] push_data;
  logic [CNT_W-1:0] count;
  logic [CNT_W+1:0] stat_q;
  always_comb begin
    f3 = bus.req_funct3;
    a = bus.req_addr[1:0];
    mmio = bus.req_addr[MMIO_BIT];
    bad = (bus.req_we ? f3 > 3'b010 : (f3 == 3'b011 || f3[2:1] == 2'b11)) ||
          (f3[1:0] == 2'b01 ? a[0] : f3[1:0] == 2'b10 && a != 2'b00);
    stall = bus.req_valid & ~bad & mmio & bus.req_we & full;
    accept = bus.req_valid & ~bad & ~stall;
    cs = accept & ~mmio;
    we = cs & bus.req_we;
    push = accept & mmio & bus.req_we;
    push_data = bus.req_wdata[{(f3 == F3_B ? a : 2'b00), 3'b000} +: 8];
    bus.req_stall = stall;
    bus.req_err = bus.req_valid & bad;
    bus.mem_cs = cs;
    bus.mem_we = we;
    bus.mem_addr = cs ? {bus.req_addr[ADDR_W-1:2], 2'b00} : '0;
    bus.mem_wdata = ~we ? '0 : f3 == F3_B ? {4{bus.req_wdata[7:0]}} :
                    f3 == F3_H ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    bus.mem_mask = ~cs ? 4'h0 : bus.req_we ? lane_mask(f3, a) : 4'hf;
    bus.ld_valid = ld_valid_q;
    bus.ld_data = ~ld_valid_q ? '0 : ld_mmio_q ? 32'(stat_q) : load_extend(ld_f3_q, ld_a_q, bus.mem_rdata);
    bus.uart_valid = ~empty;
    bus.fifo_count = count;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_valid_q <= 1'b0;
      ld_mmio_q <= 1'b0;
      ld_f3_q <= 3'b0;
      ld_a_q <= 2'b0;
      stat_q <= '0;
    end else begin
      ld_valid_q <= accept & ~bus.req_we;
      if (accept & ~bus.req_we) begin
        ld_mmio_q <= mmio;
        ld_f3_q <= f3;
        ld_a_q <= a;
        stat_q <= {count, full, empty};
      end
    end
  end
  tx_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(~empty & bus.uart_ready),
    .din(push_data),
    .dout(bus.uart_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_lsu_mmio_unit.sv
// tb_lsu_mmio_unit: scoreboard bench for lsu_mmio_unit (load results and UART bytes checked against queues)
module tb_lsu_mmio_unit;
  import lsu_mmio_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  logic [31:0] ld_q[$];
  logic [7:0] uart_q[$];
  always #5 clk = ~clk;
  lsu_mmio_unit_if #(.ADDR_W(32), .CNT_W(4)) bus();
  lsu_mmio_unit dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.ld_valid === 1'b1) begin
      if (ld_q.size() == 0) chk("ld_unexpected", 32'(bus.ld_valid), 32'h0);
      else chk("ld_data", bus.ld_data, ld_q.pop_front());
    end
    if (bus.uart_valid === 1'b1 && bus.uart_ready === 1'b1) begin
      if (uart_q.size() == 0) chk("uart_unexpected", 32'(bus.uart_valid), 32'h0);
      else chk("uart_data", 32'(bus.uart_data), 32'(uart_q.pop_front()));
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
  endtask
  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    #1;
  endtask
  task automatic store_mem(input string tag, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] mask, input logic [31:0] ewd);
    req(1'b1, f3, addr, wd);
    chk({tag, "_cs"}, 32'(bus.mem_cs), 32'h1);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'h1);
    chk({tag, "_mask"}, 32'(bus.mem_mask), 32'(mask));
    chk({tag, "_wdata"}, bus.mem_wdata, ewd);
    chk({tag, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    step;
    idle;
  endtask
  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd,
                      input logic [31:0] exp);
    req(1'b0, f3, addr, 32'h0);
    chk({tag, "_err"}, 32'(bus.req_err), 32'h0);
    if (addr[31]) chk({tag, "_mmio_cs"}, 32'(bus.mem_cs), 32'h0);
    else begin
      chk({tag, "_cs"}, 32'(bus.mem_cs), 32'h1);
      chk({tag, "_we"}, 32'(bus.mem_we), 32'h0);
      chk({tag, "_mask"}, 32'(bus.mem_mask), 32'hf);
    end
    ld_q.push_back(exp);
    step;
    idle;
    bus.mem_rdata = rd;
  endtask
  task automatic err_req(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr);
    req(we, f3, addr, 32'h12345678);
    chk({tag, "_err"}, 32'(bus.req_err), 32'h1);
    chk({tag, "_cs"}, 32'(bus.mem_cs), 32'h0);
    chk({tag, "_stall"}, 32'(bus.req_stall), 32'h0);
    step;
    idle;
  endtask
  task automatic push(input string tag, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [7:0] b);
    req(1'b1, f3, addr, wd);
    chk({tag, "_stall"}, 32'(bus.req_stall), 32'h0);
    chk({tag, "_cs"}, 32'(bus.mem_cs), 32'h0);
    uart_q.push_back(b);
    step;
    idle;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] wd;
    idle;
    bus.mem_rdata = 32'h0;
    bus.uart_ready = 1'b0;
    repeat (2) step;
    chk("rst_ld_valid", 32'(bus.ld_valid), 32'h0);
    chk("rst_ld_data", bus.ld_data, 32'h0);
    chk("rst_count", 32'(bus.fifo_count), 32'h0);
    chk("rst_uart_valid", 32'(bus.uart_valid), 32'h0);
    chk("idle_cs", 32'(bus.mem_cs), 32'h0);
    chk("idle_stall", 32'(bus.req_stall), 32'h0);
    rst_n = 1'b1;
    step;
    store_mem("sw", F3_W, 32'h100, 32'hDEADBEEF, 4'hf, 32'hDEADBEEF);
    load("lb", F3_B, 32'h103, 32'hDEADBEEF, 32'hFFFFFFDE);
    store_mem("sh", F3_H, 32'h102, 32'hABCD1234, 4'hc, 32'h12341234);
    store_mem("sh_lo", F3_H, 32'h100, 32'h0000BEEF, 4'h3, 32'hBEEFBEEF);
    store_mem("sb", F3_B, 32'h102, 32'h00000077, 4'h4, 32'h77777777);
    load("lhu", F3_HU, 32'h102, 32'h80010000, 32'h00008001);
    load("lh", F3_H, 32'h102, 32'h80010000, 32'hFFFF8001);
    load("lbu", F3_BU, 32'h101, 32'h00008000, 32'h00000080);
    load("lh_lo", F3_H, 32'h100, 32'h00007FFF, 32'h00007FFF);
    load("lw", F3_W, 32'h104, 32'h12345678, 32'h12345678);
    err_req("lw_mis", 1'b0, F3_W, 32'h101);
    err_req("lh_mis", 1'b0, F3_H, 32'h003);
    err_req("f3_011", 1'b0, 3'b011, 32'h0);
    err_req("st_f3_100", 1'b1, 3'b100, 32'h0);
    err_req("sw_mis_mmio", 1'b1, F3_W, 32'h80000002);
    repeat (2) step;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        wd = 32'hA5A5A5A5;
        wd[8*i +: 8] = 8'h41 + 8'(i);
        push("push_sb", F3_B, 32'h80000000 + 32'(i), wd, 8'h41 + 8'(i));
      end else push("push_shw", i[0] ? F3_W : F3_H, 32'h80000000, {24'hC3C3C3, 8'h41 + 8'(i)}, 8'h41 + 8'(i));
    end
    chk("full_count", 32'(bus.fifo_count), 32'h8);
    chk("full_uart_valid", 32'(bus.uart_valid), 32'h1);
    chk("head_byte", 32'(bus.uart_data), 32'h41);
    repeat (3) begin
      req(1'b1, F3_B, 32'h80000000, 32'h49);
      chk("stall_full", 32'(bus.req_stall), 32'h1);
      chk("stall_cs", 32'(bus.mem_cs), 32'h0);
      step;
    end
    chk("stall_count", 32'(bus.fifo_count), 32'h8);
    bus.uart_ready = 1'b1;
    #1;
    chk("stall_with_pop", 32'(bus.req_stall), 32'h1);
    step;
    bus.uart_ready = 1'b0;
    #1;
    chk("pop_count7", 32'(bus.fifo_count), 32'h7);
    chk("unstall", 32'(bus.req_stall), 32'h0);
    uart_q.push_back(8'h49);
    step;
    idle;
    chk("refill_count", 32'(bus.fifo_count), 32'h8);
    load("stat_full", F3_W, 32'h80000000, 32'h0, 32'h22);
    bus.uart_ready = 1'b1;
    repeat (5) step;
    chk("drain_count3", 32'(bus.fifo_count), 32'h3);
    req(1'b1, F3_B, 32'h80000000, 32'h4A);
    chk("pushpop_stall", 32'(bus.req_stall), 32'h0);
    uart_q.push_back(8'h4A);
    step;
    idle;
    bus.uart_ready = 1'b0;
    #1;
    chk("pushpop_count", 32'(bus.fifo_count), 32'h3);
    chk("pushpop_head", 32'(bus.uart_data), 32'h48);
    load("stat3", F3_W, 32'h80000004, 32'h0, 32'h0C);
    push("push_4b", F3_B, 32'h80000000, 32'h4B, 8'h4B);
    push("push_4c", F3_B, 32'h80000000, 32'h4C, 8'h4C);
    chk("count5", 32'(bus.fifo_count), 32'h5);
    rst_n = 1'b0;
    req(1'b0, F3_W, 32'h200, 32'h0);
    step;
    idle;
    uart_q.delete();
    chk("mid_rst_count", 32'(bus.fifo_count), 32'h0);
    chk("mid_rst_uart_valid", 32'(bus.uart_valid), 32'h0);
    chk("mid_rst_ld_valid", 32'(bus.ld_valid), 32'h0);
    rst_n = 1'b1;
    step;
    push("post_rst", F3_B, 32'h80000001, 32'h00005500, 8'h55);
    chk("post_rst_count", 32'(bus.fifo_count), 32'h1);
    chk("post_rst_head", 32'(bus.uart_data), 32'h55);
    bus.uart_ready = 1'b1;
    step;
    bus.uart_ready = 1'b0;
    #1;
    chk("final_count", 32'(bus.fifo_count), 32'h0);
    chk("final_uart_valid", 32'(bus.uart_valid), 32'h0);
    repeat (2) step;
    chk("ld_q_drained", 32'(ld_q.size()), 32'h0);
    chk("uart_q_drained", 32'(uart_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
